vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 17 +
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: pixel position, active-video
// flag, sync pulses and the per-frame game-step pulse. The timing generator
// drives it through the master modport; renderers and the connector read it
// through the slave modport.
interface vga_timing_gen_if;
   logic [9:0] xCount;
   logic [9:0] yCount;
   logic       active;
   logic       hsync;
   logic       vsync;
   logic       update;

   modport master (output xCount, output yCount, output active,
                   output hsync, output vsync, output update);
   modport slave  (input xCount, input yCount, input active,
                   input hsync, input vsync, input update);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source (640x480@60 by default).
// Divides clk down to the pixel rate, scans xCount/yCount, and decodes
// hsync/vsync/active/update into registers from the next-state counters.
// Because of that, every output lines up with the position shown in the
// same cycle.
// Optional macro VGA_UPDATE_DIV_EN: adds a frame counter so that `update`
// fires only every UPDATE_DIV frames. Without the macro, `update` fires at
// every blanking entry. The raster outputs are identical in both builds.
module vga_timing_gen #(
   parameter int CLK_DIV    = 2,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int UPDATE_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // All position compares are done at the 10-bit counter width.
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;
   logic             pix_en;
   logic [9:0]       x_nxt;
   logic [9:0]       y_nxt;
   logic             blank_entry;
   logic             fire;

   // Next raster position: advance on a pixel step and wrap at line/frame end.
   always_comb begin
      pix_en = (div == DIV_LAST);
      x_nxt  = vga.xCount;
      y_nxt  = vga.yCount;
      if (pix_en) begin
         if (vga.xCount == H_LAST) begin
            x_nxt = 10'd0;
            y_nxt = (vga.yCount == V_LAST) ? 10'd0 : vga.yCount + 10'd1;
         end else begin
            x_nxt = vga.xCount + 10'd1;
         end
      end
      // Blanking entry = the step that lands on (0, V_ACTIVE).
      blank_entry = pix_en && (x_nxt == 10'd0) && (y_nxt == V_ACT);
   end

`ifdef VGA_UPDATE_DIV_EN
   localparam int FC_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(UPDATE_DIV - 1);

   logic [FC_W-1:0] fcnt;

   assign fire = (fcnt == FC_LAST);

   // Frame counter: one tick per blanking entry, wrapping at UPDATE_DIV-1.
   always_ff @(posedge clk) begin
      if (rst)
         fcnt <= '0;
      else if (blank_entry)
         fcnt <= fire ? '0 : fcnt + 1'b1;
   end
`else
   // No frame counter: every blanking entry steps the game. The compare only
   // rejects an illegal zero divisor, which is never a supported setting.
   assign fire = (UPDATE_DIV >= 1);
`endif

   // Divider, counters and output decode, all registered together so that
   // the sync, active and update outputs never skew against the position.
   always_ff @(posedge clk) begin
      if (rst) begin
         div        <= '0;
         vga.xCount <= 10'd0;
         vga.yCount <= 10'd0;
         vga.hsync  <= 1'b1;
         vga.vsync  <= 1'b1;
         vga.active <= 1'b1;
         vga.update <= 1'b0;
      end else begin
         div        <= pix_en ? '0 : div + 1'b1;
         vga.xCount <= x_nxt;
         vga.yCount <= y_nxt;
         vga.hsync  <= !((x_nxt >= HS_BEG) && (x_nxt <= HS_END));
         vga.vsync  <= !((y_nxt >= VS_BEG) && (y_nxt <= VS_END));
         vga.active <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
         // update is re-decided only on pixel steps, so it stays high for the
         // whole pixel period at (0, V_ACTIVE).
         if (pix_en)
            vga.update <= blank_entry && fire;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster: 16x12 total,
// 8x6 active, hsync low at x=10..12 and vsync low at y=8..9. It runs one
// instance with CLK_DIV=2 and one with CLK_DIV=1, and both share the reset.
module tb_vga_timing_gen;
   localparam int HT = 16;
   localparam int VT = 12;
   localparam int FRAME2 = HT * VT * 2;   // 384 clk per frame at CLK_DIV=2

`ifdef VGA_UPDATE_DIV_EN
   localparam int FIRST2  = 96*2 + 2*FRAME2;     // 3rd blanking entry: 960
   localparam int PERIOD2 = 3 * FRAME2;          // 1152
   localparam int FIRST1  = 96 + 2*(HT*VT);      // 480
   localparam int PERIOD1 = 3 * HT * VT;         // 576
`else
   localparam int FIRST2  = 192;
   localparam int PERIOD2 = FRAME2;
   localparam int FIRST1  = 96;
   localparam int PERIOD1 = HT * VT;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if v2 ();
   vga_timing_gen_if v1 ();

   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .UPDATE_DIV(3))
      u_dut2 (.clk(clk), .rst(rst), .vga(v2));

   vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .UPDATE_DIV(3))
      u_dut1 (.clk(clk), .rst(rst), .vga(v1));

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference raster: n = clk edges since reset was released.
   function automatic void model(input int n, input int cd, output int x, output int y,
                                 output int hs, output int vs, output int ac, output int up);
      int p;
      p  = n / cd;
      x  = p % HT;
      y  = (p / HT) % VT;
      hs = (x >= 10 && x <= 12) ? 0 : 1;
      vs = (y >= 8 && y <= 9) ? 0 : 1;
      ac = (x < 8 && y < 6) ? 1 : 0;
      up = (x == 0 && y == 6) ? 1 : 0;
`ifdef VGA_UPDATE_DIV_EN
      if ((p / (HT*VT)) % 3 != 2) up = 0;
`endif
   endfunction

   task automatic check_at(input int n);
      int x, y, hs, vs, ac, up;
      model(n, 2, x, y, hs, vs, ac, up);
      chk("x_div2", v2.xCount, x);     chk("y_div2", v2.yCount, y);
      chk("hsync_div2", v2.hsync, hs); chk("vsync_div2", v2.vsync, vs);
      chk("active_div2", v2.active, ac); chk("update_div2", v2.update, up);
      model(n, 1, x, y, hs, vs, ac, up);
      chk("x_div1", v1.xCount, x);     chk("y_div1", v1.yCount, y);
      chk("hsync_div1", v1.hsync, hs); chk("vsync_div1", v1.vsync, vs);
      chk("active_div1", v1.active, ac); chk("update_div1", v1.update, up);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_x"}, v2.xCount, 0);   chk({tag, "_y"}, v2.yCount, 0);
      chk({tag, "_hs"}, v2.hsync, 1);   chk({tag, "_vs"}, v2.vsync, 1);
      chk({tag, "_act"}, v2.active, 1); chk({tag, "_upd"}, v2.update, 0);
      chk({tag, "_x1"}, v1.xCount, 0);  chk({tag, "_upd1"}, v1.update, 0);
   endtask

   initial begin
      int n, rise2a, rise2b, rise1a, rise1b, w2, w1, cur2, cur1, act_cnt, found;
      logic prev2, prev1;
      rise2a = -1; rise2b = -1; rise1a = -1; rise1b = -1;
      w2 = 0; w1 = 0; cur2 = 0; cur1 = 0; act_cnt = 0; found = 0;

      // Reset held: outputs sit at their reset values.
      rst = 1'b1;
      repeat (3) tick();
      check_reset("rst_hold");

      // Release and scan several frames against the reference.
      rst = 1'b0;
      n = 0;
      check_at(0);
      act_cnt += int'(v2.active);
      prev2 = v2.update; prev1 = v1.update;
      for (int i = 1; i <= 2600; i++) begin
         tick();
         n = i;
         check_at(n);
         if (n < FRAME2) act_cnt += int'(v2.active);
         if (n == 1)  chk("edge1_x", v2.xCount, 0);
         if (n == 2)  chk("edge2_x", v2.xCount, 1);
         if (n == 31) chk("edge31_x", v2.xCount, 15);
         if (n == 32) begin chk("wrap_x", v2.xCount, 0); chk("wrap_y", v2.yCount, 1); end
         if (v2.update && !prev2) begin
            if (rise2a < 0) rise2a = n; else if (rise2b < 0) rise2b = n;
         end
         if (v1.update && !prev1) begin
            if (rise1a < 0) rise1a = n; else if (rise1b < 0) rise1b = n;
         end
         if (v2.update) cur2++; else if (prev2 && w2 == 0) w2 = cur2;
         if (v1.update) cur1++; else if (prev1 && w1 == 0) w1 = cur1;
         prev2 = v2.update; prev1 = v1.update;
      end
      chk("active_per_frame", act_cnt, 96);
      chk("first_update_div2", rise2a, FIRST2);
      chk("second_update_div2", rise2b, FIRST2 + PERIOD2);
      chk("update_width_div2", w2, 2);
      chk("first_update_div1", rise1a, FIRST1);
      chk("second_update_div1", rise1b, FIRST1 + PERIOD1);
      chk("update_width_div1", w1, 1);

      // Run on to (11,9), where both syncs are low, and reset there.
      for (int i = 0; i < 400 && found == 0; i++) begin
         if (v2.xCount == 10'd11 && v2.yCount == 10'd9) found = 1;
         else begin tick(); n++; check_at(n); end
      end
      chk("midframe_reached", found, 1);
      chk("midframe_vsync_low", v2.vsync, 0);
      rst = 1'b1;
      tick();
      check_reset("midframe_rst");
      rst = 1'b0;

      // After the restart, timing matches the first run (including fcnt=0).
      rise2a = -1;
      check_at(0);
      prev2 = v2.update;
      for (int i = 1; i <= FIRST2 + 8; i++) begin
         tick();
         check_at(i);
         if (v2.update && !prev2 && rise2a < 0) rise2a = i;
         prev2 = v2.update;
      end
      chk("restart_first_update", rise2a, FIRST2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
